// File: rtl/seq_divider_nbit_pkg.sv
// Shared constants for the sequential divider: FSM encoding and adder op select.
package seq_divider_nbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor_nbit.sv
// n-bit adder/subtractor: i_add_n = 1 computes a - b, 0 computes a + b.
module adder_subtractor_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_add_n,
  output logic [n-1:0] o_sum,
  output logic         o_cout
);

  logic [n-1:0] w_b_eff;

  // Two's-complement subtract: invert b and inject the +1 as carry-in.
  assign w_b_eff = i_b ^ {n{i_add_n}};
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + (n+1)'(i_add_n);

endmodule

// File: rtl/seq_divider_nbit.sv
// Non-restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module seq_divider_nbit
  import seq_divider_nbit_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = $clog2(n+1);

  state_t        r_state;
  logic [n:0]    r_a;
  logic [n-1:0]  r_q;
  logic [n-1:0]  r_m;
  logic [CW-1:0] r_cnt;
  logic          r_dz;

  logic [n:0]    w_a_in;
  logic [n:0]    w_b_in;
  logic [n:0]    w_sum;
  logic          w_op;
  logic          w_cout_unused;

  // RUN feeds the shifted partial remainder; FIX feeds A unchanged for the final correction.
  always_comb begin
    w_a_in = {r_a[n-1:0], r_q[n-1]};
    w_b_in = {1'b0, r_m};
    w_op   = r_a[n] ? OP_ADD : OP_SUB;
    if (r_state == FIX) begin
      w_a_in = r_a;
      w_op   = OP_ADD;
    end
  end

  adder_subtractor_nbit #(.n(n+1)) u_addsub (
    .i_a     (w_a_in),
    .i_b     (w_b_in),
    .i_add_n (w_op),
    .o_sum   (w_sum),
    .o_cout  (w_cout_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_dz      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= dividend;
            r_m     <= divisor;
            r_cnt   <= '0;
            r_dz    <= (divisor == '0);
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_sum;
          r_q   <= {r_q[n-2:0], ~w_sum[n]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(n-1)) r_state <= FIX;
        end
        FIX: begin
          r_a       <= r_a[n] ? w_sum : r_a;
          quotient  <= r_q;
          remainder <= r_a[n] ? w_sum[n-1:0] : r_a[n-1:0];
          div_zero  <= r_dz;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nbit.sv
// Randomized and directed checks of seq_divider_nbit (n=4 and n=8) against an arithmetic model.
module tb_seq_divider_nbit;

  logic       clk, rst_n;
  logic       start4, busy4, done4, dz4;
  logic [3:0] dvd4, dvs4, q4, r4;
  logic       start8, busy8, done8, dz8;
  logic [7:0] dvd8, dvs8, q8, r8;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider_nbit #(.n(4)) u_dut4 (
    .clk(clk), .reset_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_zero(dz4)
  );

  seq_divider_nbit #(.n(8)) u_dut8 (
    .clk(clk), .reset_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: quotient all ones / remainder = dividend when dividing by zero.
  function automatic logic [7:0] ref_q(input int w, input int a, input int b);
    return (b == 0) ? 8'((1 << w) - 1) : 8'(a / b);
  endfunction
  function automatic logic [7:0] ref_r(input int a, input int b);
    return (b == 0) ? 8'(a) : 8'(a % b);
  endfunction

  // Called at a negedge; returns at the negedge following the done edge.
  task automatic div4(input logic [3:0] a, input logic [3:0] b);
    int cyc = 0;
    int bc  = 0;
    dvd4 = a; dvs4 = b; start4 = 1'b1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
      if (busy4) bc++;
      if (done4) break;
    end
    chk("lat4", cyc, 6);
    chk("busy4_cycles", bc, 5);
    chk("q4", q4, 32'(ref_q(4, a, b)));
    chk("r4", r4, 32'(ref_r(a, b)));
    chk("dz4", dz4, (b == 0));
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b);
    int cyc = 0;
    int bc  = 0;
    dvd8 = a; dvs8 = b; start8 = 1'b1;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (busy8) bc++;
      if (done8) break;
    end
    chk("lat8", cyc, 10);
    chk("busy8_cycles", bc, 9);
    chk("q8", q8, 32'(ref_q(8, a, b)));
    chk("r8", r8, 32'(ref_r(a, b)));
    chk("dz8", dz8, (b == 0));
  endtask

  initial begin
    int cyc;
    int dn;
    rst_n = 1'b0;
    start4 = 1'b0; dvd4 = '0; dvs4 = '0;
    start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q4, 0);
    chk("rst_r", r4, 0);
    chk("rst_dz", dz4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    rst_n = 1'b1;

    // Basic, done is a single-cycle pulse
    div4(4'd13, 4'd3);
    @(negedge clk);
    chk("done_pulse", done4, 0);

    div4(4'd15, 4'd1);
    div4(4'd3, 4'd9);
    div4(4'd0, 4'd5);

    // start held high through the run with changing operands
    dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done4) break;
      chk("hold_q_prev", q4, 0);
      chk("hold_busy", busy4, 1);
      dvd4 = 4'($urandom); dvs4 = 4'($urandom);
    end
    chk("hold_lat", cyc, 6);
    chk("hold_q", q4, 32'(ref_q(4, 13, 3)));
    chk("hold_r", r4, 32'(ref_r(13, 3)));
    dvd4 = 4'd11; dvs4 = 4'd2;
    @(negedge clk);
    chk("b2b_accept", busy4, 1);
    start4 = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done4) break;
      chk("b2b_hold_q", q4, 32'(ref_q(4, 13, 3)));
    end
    chk("b2b_lat", cyc, 6);
    chk("b2b_q", q4, 32'(ref_q(4, 11, 2)));
    chk("b2b_r", r4, 32'(ref_r(11, 2)));

    div4(4'd7, 4'd0);
    div4(4'd8, 4'd2);

    // Reset during the third RUN cycle
    dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_done", done4, 0);
    chk("mid_rst_q", q4, 0);
    chk("mid_rst_r", r4, 0);
    chk("mid_rst_dz", dz4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk("no_done_after_abort", dn, 0);
    div4(4'd9, 4'd4);

    // Exhaustive n=4 sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        div4(4'(a), 4'(b));

    // Random n=8 pairs, with forced zero and edge divisors
    div8(8'd200, 8'd0);
    div8(8'd255, 8'd1);
    div8(8'd7, 8'd255);
    for (int i = 0; i < 200; i++)
      div8(8'($urandom), 8'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
